mux_arb_nx: RTL and testbench

//  Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshake on every input and on the output.
//  Two grant modes: software-steered select or round-robin arbitration.

---
 rtl/mux_arb_nx.sv | 102 ++++++++++
 tb/tb_mux_arb_nx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_nx.sv
// N-channel registered multiplexer with valid/ready on every port.
// The grant is steered by sel (MODE=0) or by a round-robin pointer (MODE=1).
module mux_arb_nx #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int MODE  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_vld,
    input  logic [NCH*WIDTH-1:0] in_dat,
    output logic [NCH-1:0]       in_rdy,
    input  logic [SELW-1:0]      sel,
    output logic                 out_vld,
    output logic [WIDTH-1:0]     out_dat,
    input  logic                 out_rdy,
    output logic [SELW-1:0]      gnt_idx
);

    logic [NCH-1:0]   gnt;
    logic [SELW-1:0]  gidx_c;
    logic [WIDTH-1:0] dat_c;
    logic             found;
    int               c;
    logic             load;
    logic             xfer;

    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_dat_q, out_dat_d;
    logic [SELW-1:0]  gnt_idx_q, gnt_idx_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    always_comb begin
        gnt    = '0;
        gidx_c = '0;
        dat_c  = '0;
        found  = 1'b0;
        c      = 0;
        if (MODE == 0) begin
            // sel values at or above NCH match no channel, so nothing is granted
            for (int i = 0; i < NCH; i++) begin
                if (sel == SELW'(i) && in_vld[i]) begin
                    gnt[i] = 1'b1;
                    gidx_c = SELW'(i);
                    dat_c  = in_dat[i*WIDTH +: WIDTH];
                end
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                c = int'(ptr_q) + k;
                if (c >= NCH) c = c - NCH;
                if (!found && in_vld[c]) begin
                    found  = 1'b1;
                    gnt[c] = 1'b1;
                    gidx_c = SELW'(c);
                    dat_c  = in_dat[c*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign load   = ~out_vld_q | out_rdy;
    assign in_rdy = gnt & {NCH{load & rst_n}};
    assign xfer   = |in_rdy;

    always_comb begin
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        if (xfer) begin
            out_vld_d = 1'b1;
            out_dat_d = dat_c;
            gnt_idx_d = gidx_c;
            if (MODE == 1) begin
                ptr_d = (gidx_c == SELW'(NCH-1)) ? '0 : gidx_c + SELW'(1);
            end
        end else if (out_vld_q && out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
        end
    end

    assign out_vld = out_vld_q;
    assign out_dat = out_dat_q;
    assign gnt_idx = gnt_idx_q;

endmodule

// File: tb/tb_mux_arb_nx.sv
// Bench for mux_arb_nx: a fixed-select instance (SELW=3) and a round-robin instance side by side.
module tb_mux_arb_nx;

    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]   a_vld, a_rdy, b_vld, b_rdy;
    logic [N*W-1:0] a_dat, b_dat;
    logic [2:0]     a_sel;
    logic [1:0]     b_sel, b_gidx;
    logic [2:0]     a_gidx;
    logic           a_ordy, a_ovld, b_ordy, b_ovld;
    logic [W-1:0]   a_odat, b_odat;

    mux_arb_nx #(.WIDTH(W), .NCH(N), .SELW(3), .MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .in_vld(a_vld), .in_dat(a_dat), .in_rdy(a_rdy),
        .sel(a_sel), .out_vld(a_ovld), .out_dat(a_odat), .out_rdy(a_ordy), .gnt_idx(a_gidx));

    mux_arb_nx #(.WIDTH(W), .NCH(N), .SELW(2), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_vld(b_vld), .in_dat(b_dat), .in_rdy(b_rdy),
        .sel(b_sel), .out_vld(b_ovld), .out_dat(b_odat), .out_rdy(b_ordy), .gnt_idx(b_gidx));

    int n_cmp = 0;
    int n_err = 0;

    // reference state: what each output register should hold
    bit       ma_vld, mb_vld;
    int       ma_idx, mb_idx, mb_ptr;
    logic [W-1:0] ma_dat, mb_dat;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ref_grant(input int mode, input logic [N-1:0] vld, input int sl, input int ptr);
        if (mode == 0) return (sl < N && vld[sl]) ? sl : -1;
        for (int k = 0; k < N; k++) begin
            if (vld[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // one clock: compare both DUTs against the model, then advance the model
    task automatic cycle();
        int ga, gb;
        bit la, lb;
        #1;
        ga = ref_grant(0, a_vld, int'(a_sel), 0);
        gb = ref_grant(1, b_vld, 0, mb_ptr);
        la = rst_n && (!ma_vld || a_ordy);
        lb = rst_n && (!mb_vld || b_ordy);
        chk("a_in_rdy", a_rdy, la ? onehot(ga) : '0);
        chk("a_out_vld", a_ovld, ma_vld);
        chk("a_out_dat", a_odat, ma_dat);
        chk("a_gnt_idx", a_gidx, ma_idx);
        chk("b_in_rdy", b_rdy, lb ? onehot(gb) : '0);
        chk("b_out_vld", b_ovld, mb_vld);
        chk("b_out_dat", b_odat, mb_dat);
        chk("b_gnt_idx", b_gidx, mb_idx);
        @(posedge clk);
        if (!rst_n) begin
            ma_vld = 0; ma_dat = '0; ma_idx = 0;
            mb_vld = 0; mb_dat = '0; mb_idx = 0; mb_ptr = 0;
        end else begin
            if (la && ga >= 0) begin
                ma_vld = 1; ma_dat = a_dat[ga*W +: W]; ma_idx = ga;
            end else if (ma_vld && a_ordy) ma_vld = 0;
            if (lb && gb >= 0) begin
                mb_vld = 1; mb_dat = b_dat[gb*W +: W]; mb_idx = gb;
                mb_ptr = (gb + 1) % N;
            end else if (mb_vld && b_ordy) mb_vld = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] vld;
        logic [2:0]   sel;
        logic [N-1:0] exp_rdy;
        logic         exp_ovld;
        logic [W-1:0] exp_dat;
        logic [2:0]   exp_idx;
    } vec_t;

    vec_t tbl[9];
    int   t3_seq[6];
    int   t4_seq[7];

    initial begin
        tbl[0] = '{4'b1111, 3'd2, 4'b0100, 1'b1, 32'hA5, 3'd2};
        tbl[1] = '{4'b1111, 3'd5, 4'b0000, 1'b0, 32'hA5, 3'd2};
        tbl[2] = '{4'b1111, 3'd7, 4'b0000, 1'b0, 32'hA5, 3'd2};
        tbl[3] = '{4'b1111, 3'd4, 4'b0000, 1'b0, 32'hA5, 3'd2};
        tbl[4] = '{4'b0111, 3'd3, 4'b0000, 1'b0, 32'hA5, 3'd2};
        tbl[5] = '{4'b1000, 3'd3, 4'b1000, 1'b1, 32'hA3, 3'd3};
        tbl[6] = '{4'b0001, 3'd0, 4'b0001, 1'b1, 32'hA0, 3'd0};
        tbl[7] = '{4'b0010, 3'd0, 4'b0000, 1'b0, 32'hA0, 3'd0};
        tbl[8] = '{4'b0010, 3'd1, 4'b0010, 1'b1, 32'hA1, 3'd1};
        t3_seq = '{0, 1, 2, 3, 0, 1};
        t4_seq = '{1, 3, 1, 3, 1, 1, 1};

        ma_vld = 0; ma_dat = '0; ma_idx = 0;
        mb_vld = 0; mb_dat = '0; mb_idx = 0; mb_ptr = 0;
        a_vld = '0; b_vld = '0; a_sel = '0; b_sel = '0; a_ordy = 1; b_ordy = 1;
        a_dat = {32'hA3, 32'hA5, 32'hA1, 32'hA0};
        b_dat = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        rst_n = 1'b0;
        @(posedge clk); #1;
        do_reset();
        chk("reset_out_vld", {a_ovld, b_ovld}, 2'b00);
        chk("reset_gnt_idx", {a_gidx, b_gidx}, 5'd0);

        // out-of-range select never grants
        a_vld = 4'b1111; a_sel = 3'd5;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("sel_oob_in_rdy", a_rdy, 4'b0000);
            chk("sel_oob_out_vld", a_ovld, 1'b0);
            cycle();
        end

        for (int i = 0; i < 9; i++) begin
            a_vld = tbl[i].vld; a_sel = tbl[i].sel; a_ordy = 1'b1;
            #1;
            chk($sformatf("tbl%0d_in_rdy", i), a_rdy, tbl[i].exp_rdy);
            cycle();
            chk($sformatf("tbl%0d_out_vld", i), a_ovld, tbl[i].exp_ovld);
            chk($sformatf("tbl%0d_out_dat", i), a_odat, tbl[i].exp_dat);
            chk($sformatf("tbl%0d_gnt_idx", i), a_gidx, tbl[i].exp_idx);
        end
        a_vld = '0;

        // round-robin rotation with all channels busy
        do_reset();
        b_vld = 4'b1111; b_ordy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("rr_all_gnt", b_gidx, t3_seq[i]);
            chk("rr_all_vld", b_ovld, 1'b1);
        end

        // sparse requesters, then one drops out so the pointer must wrap
        do_reset();
        b_vld = 4'b1010;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) b_vld = 4'b0010;
            cycle();
            chk("rr_sparse_gnt", b_gidx, t4_seq[i]);
        end

        // back-pressure, then drain and refill in the same cycle
        do_reset();
        b_vld = 4'b1111; b_ordy = 1'b1;
        cycle();
        b_ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_rdy", b_rdy, 4'b0000);
            cycle();
            chk("stall_gnt", b_gidx, 2'd0);
            chk("stall_dat", b_odat, 32'hB0);
        end
        b_ordy = 1'b1;
        cycle();
        chk("refill_vld", b_ovld, 1'b1);
        chk("refill_gnt", b_gidx, 2'd1);
        chk("refill_dat", b_odat, 32'hB1);

        // reset while a word is held
        rst_n = 1'b0;
        cycle();
        chk("midrst_vld", b_ovld, 1'b0);
        chk("midrst_dat", b_odat, 32'h0);
        chk("midrst_gnt", b_gidx, 2'd0);
        rst_n = 1'b1;
        b_vld = 4'b1100;
        cycle();
        chk("post_rst_gnt", b_gidx, 2'd2);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            a_vld  = 4'($urandom);
            b_vld  = 4'($urandom);
            a_sel  = 3'($urandom);
            b_sel  = 2'($urandom);
            a_ordy = ($urandom_range(0, 3) != 0);
            b_ordy = ($urandom_range(0, 3) != 0);
            for (int ch = 0; ch < N; ch++) begin
                if (!(ma_vld && !a_ordy)) a_dat[ch*W +: W] = $urandom;
                b_dat[ch*W +: W] = $urandom;
            end
            rst_n = ($urandom_range(0, 49) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
